// File: rtl/mod_reg_banderas_pkg.sv
// rtl/mod_reg_banderas_pkg.sv - shared constants for the flag register skid buffer
package mod_reg_banderas_pkg;

  localparam int ANCHO_DEF = 6;

  localparam int BIT_ZF = 0;
  localparam int BIT_SF = 1;
  localparam int BIT_CF = 2;
  localparam int BIT_OF = 3;

  localparam logic [1:0] VACIO = 2'd0;
  localparam logic [1:0] UNO   = 2'd1;
  localparam logic [1:0] LLENO = 2'd2;

  typedef logic [3:0] banderas_t;

endpackage

// File: rtl/mod_reg_banderas_if.sv
// rtl/mod_reg_banderas_if.sv - upstream/downstream handshake bundle
interface mod_reg_banderas_if
  import mod_reg_banderas_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [ANCHO-1:0] resultado;
  logic             acarreo;
  logic             desborde;
  logic             out_valid;
  logic             out_ready;
  logic [ANCHO-1:0] out_resultado;
  banderas_t        out_banderas;

  modport slave (
    input  in_valid, resultado, acarreo, desborde, out_ready,
    output in_ready, out_valid, out_resultado, out_banderas
  );

  modport master (
    output in_valid, resultado, acarreo, desborde, out_ready,
    input  in_ready, out_valid, out_resultado, out_banderas
  );
endinterface

// File: rtl/mod_reg_banderas_calc.sv
// rtl/mod_reg_banderas_calc.sv - combinational {OF,CF,SF,ZF} from an ALU word
module mod_calc_banderas
  import mod_reg_banderas_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic [ANCHO-1:0] i_resultado,
  input  logic             i_acarreo,
  input  logic             i_desborde,
  output banderas_t        o_banderas
);

  always_comb begin
    o_banderas         = '0;
    o_banderas[BIT_ZF] = (i_resultado == '0);
    o_banderas[BIT_SF] = i_resultado[ANCHO-1];
    o_banderas[BIT_CF] = i_acarreo;
    o_banderas[BIT_OF] = i_desborde;
  end

endmodule

// File: rtl/mod_reg_banderas.sv
// rtl/mod_reg_banderas.sv - 2-entry skid buffer for ALU words with flags, sticky flags and transfer count
module mod_reg_banderas
  import mod_reg_banderas_pkg::*;
#(
  parameter int ANCHO    = ANCHO_DEF,
  parameter int CONTEO_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mod_reg_banderas_if.slave   bus,
  input  logic                limpiar,
  output logic [3:0]          pegajosas,
  output logic [CONTEO_W-1:0] conteo
);

  logic [1:0]          r_estado;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [ANCHO-1:0]    r_pri_res;
  banderas_t           r_pri_ban;
  logic [ANCHO-1:0]    r_sec_res;
  banderas_t           r_sec_ban;
  banderas_t           r_pegajosas;
  logic [CONTEO_W-1:0] r_conteo;

  logic                w_in_xfer;
  logic                w_out_xfer;
  banderas_t           w_ban_nueva;
  logic [1:0]          w_estado_sig;

  mod_calc_banderas #(.ANCHO(ANCHO)) u_calc (
    .i_resultado (bus.resultado),
    .i_acarreo   (bus.acarreo),
    .i_desborde  (bus.desborde),
    .o_banderas  (w_ban_nueva)
  );

  assign w_in_xfer  = bus.in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && bus.out_ready;

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      VACIO: if (w_in_xfer) w_estado_sig = UNO;
      UNO: begin
        if (w_in_xfer && !w_out_xfer)      w_estado_sig = LLENO;
        else if (!w_in_xfer && w_out_xfer) w_estado_sig = VACIO;
      end
      LLENO: if (w_out_xfer) w_estado_sig = UNO;
      default: w_estado_sig = VACIO;
    endcase
  end

  // Handshake outputs are registered copies of the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= VACIO;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_pri_res   <= '0;
      r_pri_ban   <= '0;
      r_sec_res   <= '0;
      r_sec_ban   <= '0;
    end else begin
      r_estado    <= w_estado_sig;
      r_in_ready  <= (w_estado_sig != LLENO);
      r_out_valid <= (w_estado_sig != VACIO);
      case (r_estado)
        VACIO: begin
          if (w_in_xfer) begin
            r_pri_res <= bus.resultado;
            r_pri_ban <= w_ban_nueva;
          end
        end
        UNO: begin
          if (w_in_xfer && w_out_xfer) begin
            r_pri_res <= bus.resultado;
            r_pri_ban <= w_ban_nueva;
          end else if (w_in_xfer) begin
            r_sec_res <= bus.resultado;
            r_sec_ban <= w_ban_nueva;
          end
        end
        LLENO: begin
          if (w_out_xfer) begin
            r_pri_res <= r_sec_res;
            r_pri_ban <= r_sec_ban;
          end
        end
        default: ;
      endcase
    end
  end

  // A clear coinciding with a transfer restarts accounting with that word included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pegajosas <= '0;
      r_conteo    <= '0;
    end else if (limpiar) begin
      r_pegajosas <= w_out_xfer ? r_pri_ban : '0;
      r_conteo    <= w_out_xfer ? CONTEO_W'(1) : '0;
    end else if (w_out_xfer) begin
      r_pegajosas <= r_pegajosas | r_pri_ban;
      if (r_conteo != {CONTEO_W{1'b1}}) r_conteo <= r_conteo + CONTEO_W'(1);
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_resultado = r_pri_res;
  assign bus.out_banderas  = r_pri_ban;
  assign pegajosas         = r_pegajosas;
  assign conteo            = r_conteo;

endmodule

// File: tb/tb_mod_reg_banderas.sv
// tb/tb_mod_reg_banderas.sv - self-checking bench for mod_reg_banderas
module tb_mod_reg_banderas;

  localparam int ANCHO    = 6;
  localparam int CONTEO_W = 8;

  typedef struct {
    logic [5:0] res;
    logic       c;
    logic       o;
    logic [3:0] ban;
  } vec_t;

  typedef struct {
    logic [5:0] res;
    logic [3:0] ban;
  } item_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                limpiar = 1'b0;
  logic [3:0]          pegajosas;
  logic [CONTEO_W-1:0] conteo;

  mod_reg_banderas_if #(.ANCHO(ANCHO)) bus ();

  mod_reg_banderas #(.ANCHO(ANCHO), .CONTEO_W(CONTEO_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .limpiar   (limpiar),
    .pegajosas (pegajosas),
    .conteo    (conteo)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  item_t      sb[$];
  logic [3:0] m_peg = '0;
  int         m_cnt = 0;
  logic       chk_en = 1'b0;
  logic       hold_prev = 1'b0;
  logic [5:0] prev_res;
  logic [3:0] prev_ban;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags_of(input logic [5:0] r, input logic c, input logic o);
    return {o, c, r[5], (r == 6'd0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: observe handshakes mid-cycle, before the edge that acts on them.
  always @(negedge clk) begin
    if (chk_en) begin
      item_t e;
      logic  ox;
      logic [3:0] eb;
      eb = '0;
      if (hold_prev) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_res", int'(bus.out_resultado), int'(prev_res));
        chk("hold_ban", int'(bus.out_banderas), int'(prev_ban));
      end
      chk("sb_out_valid", int'(bus.out_valid), int'(sb.size() != 0));
      chk("sb_in_ready", int'(bus.in_ready), int'(sb.size() < 2));
      chk("sticky", int'(pegajosas), int'(m_peg));
      chk("count", int'(conteo), m_cnt);
      ox = bus.out_valid && bus.out_ready;
      if (ox && sb.size() != 0) begin
        e = sb.pop_front();
        eb = e.ban;
        chk("out_res", int'(bus.out_resultado), int'(e.res));
        chk("out_ban", int'(bus.out_banderas), int'(e.ban));
      end
      if (limpiar) begin
        m_peg = ox ? eb : 4'd0;
        m_cnt = ox ? 1 : 0;
      end else if (ox) begin
        m_peg = m_peg | eb;
        if (m_cnt < 255) m_cnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.res = bus.resultado;
        e.ban = flags_of(bus.resultado, bus.acarreo, bus.desborde);
        sb.push_back(e);
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_res  = bus.out_resultado;
      prev_ban  = bus.out_banderas;
    end
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{6'h00, 1'b1, 1'b0, 4'b0101};
    vecs[1] = '{6'h20, 1'b0, 1'b1, 4'b1010};
    vecs[2] = '{6'h1F, 1'b0, 1'b0, 4'b0000};
    vecs[3] = '{6'h3F, 1'b1, 1'b1, 4'b1110};
    vecs[4] = '{6'h01, 1'b1, 1'b0, 4'b0100};
    vecs[5] = '{6'h00, 1'b0, 1'b1, 4'b1001};

    bus.in_valid  = 1'b0;
    bus.resultado = '0;
    bus.acarreo   = 1'b0;
    bus.desborde  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values, in_ready held low during reset and high one edge after release
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_res", int'(bus.out_resultado), 0);
    chk("rst_out_ban", int'(bus.out_banderas), 0);
    chk("rst_sticky", int'(pegajosas), 0);
    chk("rst_count", int'(conteo), 0);
    step();
    step();
    chk("rst_in_ready_held", int'(bus.in_ready), 0);
    #2 rst_n = 1'b1;
    step();
    chk("rel_in_ready", int'(bus.in_ready), 1);
    chk("rel_out_valid", int'(bus.out_valid), 0);
    chk_en = 1'b1;

    // Table vectors: one word each, 1-cycle latency, garbage inputs while idle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = 1'b1;
      bus.resultado = vecs[i].res;
      bus.acarreo   = vecs[i].c;
      bus.desborde  = vecs[i].o;
      step();
      bus.in_valid  = 1'b0;
      bus.resultado = 6'($urandom);
      bus.acarreo   = 1'($urandom);
      bus.desborde  = 1'($urandom);
      chk("vec_valid", int'(bus.out_valid), 1);
      chk("vec_res", int'(bus.out_resultado), int'(vecs[i].res));
      chk("vec_ban", int'(bus.out_banderas), int'(vecs[i].ban));
      step();
      if (i == 0) chk("first_count", int'(conteo), 1);
      chk("vec_drained", int'(bus.out_valid), 0);
    end

    // Back-pressure fills the skid entry, then drains in order on consecutive cycles
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.acarreo   = 1'b0;
    bus.desborde  = 1'b0;
    bus.resultado = 6'h21;
    step();
    bus.resultado = 6'h05;
    step();
    bus.in_valid = 1'b0;
    chk("full_in_ready", int'(bus.in_ready), 0);
    chk("full_res", int'(bus.out_resultado), 6'h21);
    step();
    chk("full_res_held", int'(bus.out_resultado), 6'h21);
    bus.out_ready = 1'b1;
    step();
    chk("drain_second", int'(bus.out_resultado), 6'h05);
    chk("drain_in_ready", int'(bus.in_ready), 1);
    step();
    chk("drain_empty", int'(bus.out_valid), 0);

    // Clear, then stream 64 words at full rate
    limpiar = 1'b1;
    step();
    limpiar = 1'b0;
    chk("clear_count", int'(conteo), 0);
    chk("clear_sticky", int'(pegajosas), 0);
    for (int i = 0; i < 64; i++) begin
      chk("stream_in_ready", int'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.resultado = 6'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("stream_count", int'(conteo), 64);
    chk("stream_zf", int'(pegajosas[0]), 1);
    chk("stream_sf", int'(pegajosas[1]), 1);

    // Saturation, then clear coinciding with a transfer
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'b1;
      bus.resultado = 6'($urandom);
      bus.acarreo   = 1'($urandom);
      bus.desborde  = 1'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("sat_count", int'(conteo), 255);
    bus.in_valid  = 1'b1;
    bus.resultado = 6'h3F;
    bus.acarreo   = 1'b0;
    bus.desborde  = 1'b0;
    step();
    bus.in_valid = 1'b0;
    limpiar      = 1'b1;
    step();
    limpiar = 1'b0;
    chk("clr_xfer_sticky", int'(pegajosas), 4'b0010);
    chk("clr_xfer_count", int'(conteo), 1);

    // Asynchronous reset while both entries are occupied
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.resultado = 6'h11;
    step();
    bus.resultado = 6'h12;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_full", int'(bus.in_ready), 0);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_sticky", int'(pegajosas), 0);
    chk("arst_count", int'(conteo), 0);
    chk("arst_in_ready", int'(bus.in_ready), 0);
    sb.delete();
    m_peg     = '0;
    m_cnt     = 0;
    hold_prev = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    chk_en        = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale", int'(bus.out_valid), 0);
    end
    bus.in_valid  = 1'b1;
    bus.resultado = 6'h2A;
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_res", int'(bus.out_resultado), 6'h2A);
    step();
    step();
    chk("post_rst_empty", int'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_reg_banderas.md
MOD_REG_BANDERAS -- requirements
Module: mod_reg_banderas

Interface
REQ-001 Parameter ANCHO, default 6, data width of the ALU result.
REQ-002 Parameter CONTEO_W, default 8, width of the transfer counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU word present.
REQ-006 in_ready  output  1  block can accept a word; registered.
REQ-007 resultado  input  ANCHO  ALU result.
REQ-008 acarreo  input  1  ALU carry-out.
REQ-009 desborde  input  1  ALU signed overflow.
REQ-010 out_valid  output  1  registered word available downstream.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_resultado  output  ANCHO  registered result.
REQ-013 out_banderas  output  4  {OF,CF,SF,ZF} bits [3:0] = {3,2,1,0}, for out_resultado.
REQ-014 limpiar  input  1  synchronous clear of sticky flags and counter.
REQ-015 pegajosas  output  4  OR of out_banderas over all transfers since last clear/reset.
REQ-016 conteo  output  CONTEO_W  number of output transfers since last clear/reset, saturating.

Function
REQ-017 Flags SHALL be computed at input acceptance: ZF = (resultado == 0), SF = resultado[ANCHO-1], CF = acarreo, OF = desborde.
REQ-018 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 The block SHALL be a 2-entry skid buffer with states VACIO, UNO, LLENO; words leave in acceptance order.
REQ-020 VACIO: out_valid=0, in_ready=1; input transfer -> UNO.
REQ-021 UNO: out_valid=1, in_ready=1; input only -> LLENO (new word to skid entry); output only -> VACIO; both -> UNO with new word in main entry.
REQ-022 LLENO: out_valid=1, in_ready=0; output transfer -> UNO with skid word moved to main entry the same edge.
REQ-023 Latency from input transfer to out_valid SHALL be exactly 1 cycle when the main entry is empty.
REQ-024 out_resultado/out_banderas SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 With continuous in_valid and out_ready, throughput SHALL be one word per cycle.
REQ-026 On each output transfer pegajosas |= out_banderas and conteo increments, holding at 2^CONTEO_W-1.
REQ-027 limpiar without transfer: pegajosas=0, conteo=0 next edge.
REQ-028 limpiar with simultaneous transfer: pegajosas = out_banderas of that word, conteo = 1.
REQ-029 Output values SHALL be unaffected by resultado/acarreo/desborde when no input transfer occurs.

Reset
REQ-030 rst_n low SHALL asynchronously force state VACIO, in_ready=0 while asserted and 1 on the first edge after release, out_valid=0, out_resultado=0, out_banderas=0, pegajosas=0, conteo=0.
REQ-031 Reset mid-operation SHALL discard both buffered words; no word is emitted after release until newly accepted.

Structure
REQ-032 A shared package SHALL hold ANCHO default, flag bit indices (ZF=0, SF=1, CF=2, OF=3) and the state encoding VACIO/UNO/LLENO.
REQ-033 Flag computation SHALL be a combinational sub-module mod_calc_banderas, reusable by the zero-flag logic.

Verification
REQ-034 resultado=6'b000000, acarreo=1, desborde=0, out_ready=1 -> next cycle out_valid=1, out_banderas=4'b0101, conteo=1.
REQ-035 out_ready=0, feed 6'h21 then 6'h05 -> state LLENO, in_ready=0, out_resultado=6'h21 held; raise out_ready -> 6'h21 then 6'h05 on consecutive cycles.
REQ-036 Streaming 64 words 6'h00..6'h3F with both sides always ready -> one word per cycle, order preserved, pegajosas bits ZF and SF set, conteo=64.
REQ-037 Transfer 300 words -> conteo=255 held; limpiar with concurrent transfer of 6'h3F, CF=0, OF=0 -> pegajosas=4'b0010, conteo=1.
REQ-038 rst_n pulsed low asynchronously while LLENO -> out_valid=0, pegajosas=0, conteo=0 immediately; no stale word after release.
